// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_PLLRST    = 3'd4
  } sup_state_e;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One shared timer must reach the largest terminal count minus one.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    m = max_cycles(a, b, c, d);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Flop chain that brings the asynchronous PLL lock flag into the reference clock domain.
module pll_lock_supervisor_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Plain shift chain; no reset so the data path stays a clean synchroniser.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: qualifies the synchronised lock flag, releases the system reset
// after a stable interval plus hold-off, counts lock losses and requests PLL restarts.
//
//   state      | meaning
//   WAIT_LOCK  | waiting for lock, timing out towards a PLL restart
//   STABLE     | lock seen, must stay high for STABLE_CYCLES
//   HOLD       | extra hold-off before reset release
//   RUN        | reset released, watching for lock loss
//   PLLRST     | driving the PLL restart pulse, lock flag ignored
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int PLLRST_CYCLES  = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked_in,
  output logic             rst_out,
  output logic             ready,
  output logic             pll_rst_req,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int TMR_W = timer_width(TIMEOUT_CYCLES, STABLE_CYCLES, HOLD_CYCLES, PLLRST_CYCLES);
  localparam logic [TMR_W-1:0] TC_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TC_STABLE  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TC_HOLD    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TC_PLLRST  = TMR_W'(PLLRST_CYCLES - 1);

  logic             locked_s;
  sup_state_e       state_q;
  logic [TMR_W-1:0] timer_q;
  logic             rst_out_q;
  logic             ready_q;
  logic             pll_rst_req_q;
  logic [CNT_W-1:0] lock_loss_cnt_q;
  logic [CNT_W-1:0] lock_loss_cnt_d;
  logic [CNT_W-1:0] retry_cnt_q;
  logic [CNT_W-1:0] retry_cnt_d;

  pll_lock_supervisor_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_bit (
    .clk(clk),
    .d_i(locked_in),
    .q_o(locked_s)
  );

  // Saturated next values of the event counters.
  always_comb begin
    lock_loss_cnt_d = CNT_W'(sat_inc(32'(lock_loss_cnt_q), CNT_W));
    retry_cnt_d     = CNT_W'(sat_inc(32'(retry_cnt_q), CNT_W));
  end

  // Sequencing FSM with its timer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_WAIT_LOCK;
      timer_q         <= '0;
      rst_out_q       <= 1'b1;
      ready_q         <= 1'b0;
      pll_rst_req_q   <= 1'b0;
      lock_loss_cnt_q <= '0;
      retry_cnt_q     <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= ST_STABLE;
            timer_q <= '0;
          end else if (timer_q == TC_TIMEOUT) begin
            state_q       <= ST_PLLRST;
            timer_q       <= '0;
            pll_rst_req_q <= 1'b1;
            retry_cnt_q   <= retry_cnt_d;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_q <= ST_WAIT_LOCK;
            timer_q <= '0;
          end else if (timer_q == TC_STABLE) begin
            state_q <= ST_HOLD;
            timer_q <= '0;
          end
        end
        ST_HOLD: begin
          if (!locked_s) begin
            state_q <= ST_WAIT_LOCK;
            timer_q <= '0;
          end else if (timer_q == TC_HOLD) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          // Timer is idle here; hold it rather than let it wrap.
          timer_q <= timer_q;
          if (!locked_s) begin
            state_q         <= ST_WAIT_LOCK;
            timer_q         <= '0;
            rst_out_q       <= 1'b1;
            ready_q         <= 1'b0;
            lock_loss_cnt_q <= lock_loss_cnt_d;
          end
        end
        ST_PLLRST: begin
          if (timer_q == TC_PLLRST) begin
            state_q       <= ST_WAIT_LOCK;
            timer_q       <= '0;
            pll_rst_req_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_WAIT_LOCK;
          timer_q       <= '0;
          rst_out_q     <= 1'b1;
          ready_q       <= 1'b0;
          pll_rst_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign pll_rst_req     = pll_rst_req_q;
  assign lock_loss_count = lock_loss_cnt_q;
  assign retry_count     = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus a random lock pattern,
// all compared every cycle against a counting model of the lock qualification rules.
module tb_pll_lock_supervisor;

  localparam int SYNC    = 2;
  localparam int STABLE  = 16;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 64;
  localparam int PLLRST  = 8;
  localparam int CNT_W   = 8;
  localparam int CMAX    = 255;
  localparam int REL     = SYNC + 1 + STABLE + HOLD;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             locked_in = 1'b0;
  logic             rst_out;
  logic             ready;
  logic             pll_rst_req;
  logic [CNT_W-1:0] lock_loss_count;
  logic [CNT_W-1:0] retry_count;

  pll_lock_supervisor #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TIMEOUT), .PLLRST_CYCLES(PLLRST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .locked_in(locked_in), .rst_out(rst_out), .ready(ready),
    .pll_rst_req(pll_rst_req), .lock_loss_count(lock_loss_count), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: lock samples delayed by SYNC, then counted runs of high/low samples.
  bit dl [SYNC];
  int m_pulse = 0;
  int m_wait  = 0;
  int m_good  = 0;
  bit m_run   = 1'b0;
  int m_loss  = 0;
  int m_retry = 0;

  always @(posedge clk) begin
    bit ls;
    ls = dl[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = locked_in;
    if (rst) begin
      m_pulse = 0; m_wait = 0; m_good = 0; m_run = 1'b0; m_loss = 0; m_retry = 0;
    end else if (m_pulse > 0) begin
      m_pulse--;
    end else if (m_run) begin
      if (!ls) begin
        m_run = 1'b0; m_good = 0; m_wait = 0;
        if (m_loss < CMAX) m_loss++;
      end
    end else if (m_good > 0) begin
      if (!ls) begin
        m_good = 0; m_wait = 0;
      end else begin
        m_good++;
        if (m_good == 1 + STABLE + HOLD) m_run = 1'b1;
      end
    end else begin
      if (ls) m_good = 1;
      else if (m_wait == TIMEOUT - 1) begin
        m_wait = 0; m_pulse = PLLRST;
        if (m_retry < CMAX) m_retry++;
      end else m_wait++;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rst_out", 32'(rst_out), 32'(!m_run));
      check("ready", 32'(ready), 32'(m_run));
      check("pll_rst_req", 32'(pll_rst_req), 32'(m_pulse > 0));
      check("lock_loss_count", 32'(lock_loss_count), m_loss);
      check("retry_count", 32'(retry_count), m_retry);
    end
  end

  function automatic logic sig_of(input int which);
    case (which)
      0:       return rst_out;
      1:       return ready;
      default: return pll_rst_req;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input int which, input logic val, input int budget, output int edges);
    edges = 0;
    while (sig_of(which) !== val && edges < budget) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_out"}, 32'(rst_out), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_pll_rst_req"}, 32'(pll_rst_req), 32'd0);
    check({tag, "_loss"}, 32'(lock_loss_count), 32'd0);
    check({tag, "_retry"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    int e;
    int w;
    int gap;
    int k;
    int cnt_low;

    // Reset state
    tick(5);
    chk_en = 1'b1;
    check_reset_state("reset");
    rst = 1'b0;

    // Clean lock
    tick(30);
    locked_in = 1'b1;
    wait_for(0, 1'b0, 60, e);
    check("clean_release_latency", e, REL);
    check("clean_ready", 32'(ready), 32'd1);
    check("clean_loss", 32'(lock_loss_count), 32'd0);
    check("clean_retry", 32'(retry_count), 32'd0);

    // Lock loss from RUN, then relock
    tick(10);
    locked_in = 1'b0;
    wait_for(0, 1'b1, 10, e);
    check("loss_latency", e, 3);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_count_1", 32'(lock_loss_count), 32'd1);
    check("model_loss_1", m_loss, 32'd1);
    tick(5);
    locked_in = 1'b1;
    wait_for(0, 1'b0, 60, e);
    check("relock_latency", e, REL);

    // Glitch while qualifying
    tick(5);
    locked_in = 1'b0;
    wait_for(0, 1'b1, 10, e);
    tick(5);
    locked_in = 1'b1;
    tick(10);
    locked_in = 1'b0;
    tick(5);
    check("glitch_no_release", 32'(rst_out), 32'd1);
    locked_in = 1'b1;
    wait_for(0, 1'b0, 60, e);
    check("glitch_release_latency", e, REL);
    check("glitch_loss", 32'(lock_loss_count), 32'd2);
    check("glitch_retry", 32'(retry_count), 32'd0);

    // Drop during HOLD
    tick(5);
    locked_in = 1'b0;
    wait_for(0, 1'b1, 10, e);
    tick(5);
    locked_in = 1'b1;
    tick(STABLE + 3);
    locked_in = 1'b0;
    cnt_low = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rst_out !== 1'b1) cnt_low++;
    end
    check("hold_drop_no_release", cnt_low, 0);
    check("hold_drop_loss", 32'(lock_loss_count), 32'd3);

    // Reset during HOLD
    locked_in = 1'b1;
    tick(STABLE + 4);
    rst = 1'b1;
    tick(1);
    check_reset_state("rst_in_hold");
    check("model_loss_after_rst", m_loss, 32'd0);
    rst = 1'b0;
    tick(40);
    locked_in = 1'b0;
    tick(5);

    // Timeout and PLL restart pulses
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    wait_for(2, 1'b1, 100, e);
    check("timeout_first_pulse", e, TIMEOUT);
    wait_for(2, 1'b0, 20, w);
    check("pulse_width", w, PLLRST);
    check("retry_after_one", 32'(retry_count), 32'd1);
    wait_for(2, 1'b1, 100, gap);
    check("pulse_period", w + gap, TIMEOUT + PLLRST);
    k = 0;
    while (retry_count !== 8'd255 && k < 20000) begin
      tick(1);
      k++;
    end
    tick(3 * (TIMEOUT + PLLRST));
    check("retry_saturated", 32'(retry_count), 32'd255);
    check("model_retry_sat", m_retry, 32'd255);

    // Reset in the middle of a restart pulse
    wait_for(2, 1'b1, 100, e);
    check("pulse_seen_before_rst", 32'(pll_rst_req), 32'd1);
    tick(3);
    rst = 1'b1;
    tick(1);
    check_reset_state("rst_in_pllrst");
    rst = 1'b0;

    // Random lock pattern
    for (int i = 0; i < 150; i++) begin
      int cls;
      locked_in = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 2);
      if (cls == 0)      tick($urandom_range(1, 6));
      else if (cls == 1) tick($urandom_range(8, 30));
      else               tick($urandom_range(30, 120));
    end

    // Repeated lock loss until the counter saturates
    locked_in = 1'b0;
    tick(5);
    for (int i = 0; i < 300; i++) begin
      locked_in = 1'b1;
      wait_for(1, 1'b1, 60, e);
      locked_in = 1'b0;
      wait_for(0, 1'b1, 10, e);
      tick(2);
    end
    check("loss_saturated", 32'(lock_loss_count), 32'd255);
    check("model_loss_sat", m_loss, 32'd255);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
